enemy_fire_arbiter: RTL and testbench
=====================================

ENEMY_FIRE_ARBITER -- requirements
Module: enemy_fire_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesting invaders.
REQ-002 SHALL have parameter Y_MAX, default 480, bottom screen row; projectile retired past it.
REQ-003 SHALL have parameter COOLDOWN, default 64, dclk cycles between retire and next launch.
REQ-004 SHALL have port dclk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port clr  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port play  in  1  game running; 0 forces idle.
REQ-007 SHALL have port tick  in  1  one-cycle movement strobe.
REQ-008 SHALL have port req  in  NREQ  per-invader fire request, level.
REQ-009 SHALL have port enemy_x  in  10*NREQ  packed invader x; index i at bits [10i+9:10i].
REQ-010 SHALL have port enemy_y  in  10*NREQ  packed invader y, same packing.
REQ-011 SHALL have port player_x  in  10  player x.
REQ-012 SHALL have port hit  in  1  projectile struck player; retire now.
REQ-013 SHALL have port grant  out  NREQ  one-hot, one-cycle pulse to winning invader.
REQ-014 SHALL have port proj_x  out  10  shared enemy projectile x.
REQ-015 SHALL have port proj_y  out  10  shared enemy projectile y; 0 = no projectile.
REQ-016 SHALL have port proj_active  out  1  projectile in flight.

Function
REQ-017 SHALL implement FSM IDLE, LAUNCH, FLIGHT, COOLDOWN, encoded 2 bits.
REQ-018 IDLE: when play=1 and req!=0, SHALL select winner round-robin, searching from last_winner+1 modulo NREQ, and go LAUNCH next cycle.
REQ-019 Requests whose enemy_y equals 0 SHALL be masked (off-screen invader).
REQ-020 LAUNCH (one cycle): grant[winner]=1; proj_x/proj_y SHALL load winner's enemy_x/enemy_y; last_winner<=winner; proj_active<=1; next FLIGHT.
REQ-021 Latency req-assert (in IDLE) to grant pulse SHALL be exactly 2 cycles; to proj_active=1 exactly 2 cycles.
REQ-022 FLIGHT: on tick, proj_y SHALL increment by 1; if proj_y >= Y_MAX at that tick, proj_y<=0, proj_active<=0, go COOLDOWN.
REQ-023 FLIGHT: hit=1 SHALL retire immediately (proj_y<=0, proj_active<=0, COOLDOWN), taking priority over tick same cycle.
REQ-024 COOLDOWN: 7-bit counter loads COOLDOWN-1 on entry, decrements each cycle; at 0 go IDLE; COOLDOWN=0 SHALL be treated as 1.
REQ-025 Requests outside IDLE SHALL be ignored, not queued; grant SHALL be 0 outside LAUNCH.
REQ-026 play=0 in any state SHALL synchronously force IDLE, proj_x=proj_y=0, proj_active=0, grant=0; last_winner retained.
REQ-027 proj_x SHALL stay within 0..639; arithmetic saturates, never wraps.

Reset
REQ-028 clr=1 SHALL asynchronously set state IDLE, grant=0, proj_x=0, proj_y=0, proj_active=0, cooldown counter 0, last_winner=NREQ-1 (first search starts at 0).
REQ-029 clr mid-flight SHALL drop the projectile with no grant pulse emitted.

Configuration
REQ-030 With macro ENEMY_FIRE_HOMING_EN defined, in FLIGHT on tick proj_x SHALL step 1 toward player_x (unchanged when equal), saturating 0..639.
REQ-031 Without ENEMY_FIRE_HOMING_EN, proj_x SHALL hold its LAUNCH value for the whole flight.

Verification
REQ-032 clr, play=1, req=4'b0101, all enemy_y=30 -> grant=0001 two cycles later, proj_x=enemy_x[0], proj_y=30; next launch after retire grants 0100.
REQ-033 Single launch from y=470, tick every cycle -> proj_y reaches 480, retires next tick, proj_active=0, exactly 64 cycles later IDLE accepts request.
REQ-034 hit and tick asserted same FLIGHT cycle with proj_y=200 -> proj_y=0, proj_active=0, state COOLDOWN.
REQ-035 req=1111 with enemy_y[2]=0 -> successive grants 0001, 0010, 1000, 0001; index 2 never granted.
REQ-036 HOMING_EN defined, launch at x=100, player_x=103, 5 ticks -> proj_x 101,102,103,103,103; undefined -> stays 100.
REQ-037 play dropped during FLIGHT, then clr asserted mid-COOLDOWN -> outputs zero immediately, first post-reset grant goes to index 0.

Source files
------------

// File: rtl/enemy_fire_arbiter.sv
// enemy_fire_arbiter: round-robin arbiter granting one shared enemy
// projectile to a requesting invader, then tracking its flight.
//
// Ports:
//   dclk        sole clock, rising edge
//   clr         asynchronous active-high reset
//   play        game running; 0 forces idle and clears the projectile
//   tick        one-cycle movement strobe
//   req         per-invader fire request (level), NREQ bits
//   enemy_x/y   packed invader coords, index i at [10i+9:10i]
//   player_x    player x (used for homing)
//   hit         projectile struck the player; retire now
//   grant       one-hot, one-cycle pulse to the winning invader
//   proj_x/y    shared projectile position; proj_y=0 means none
//   proj_active projectile in flight
//
// Build option: define ENEMY_FIRE_HOMING_EN to make the projectile
// drift one pixel per tick toward player_x.

module enemy_fire_arbiter #(
  parameter int NREQ     = 4,
  parameter int Y_MAX    = 480,
  parameter int COOLDOWN = 64
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              play,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [10*NREQ-1:0] enemy_x,
  input  logic [10*NREQ-1:0] enemy_y,
  input  logic [9:0]        player_x,
  input  logic              hit,
  output logic [NREQ-1:0]   grant,
  output logic [9:0]        proj_x,
  output logic [9:0]        proj_y,
  output logic              proj_active
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_TOP = 10'h3FF;
  localparam logic [9:0] Y_LIM = 10'(Y_MAX);
  // A zero cooldown still spends one cycle in COOLDOWN.
  localparam int CD_EFF = (COOLDOWN < 1) ? 1 : COOLDOWN;
  localparam logic [6:0] CD_LOAD = 7'(CD_EFF - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_FLIGHT = 2'b10,
    S_COOL   = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_d;
  logic [9:0]      px_d, py_d;
  logic            act_d;

  logic [9:0]      ex [NREQ];
  logic [9:0]      ey [NREQ];
  logic [NREQ-1:0] elig;
  logic [IW-1:0]   pick;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ex[i]   = enemy_x[10*i +: 10];
    assign ey[i]   = enemy_y[10*i +: 10];
    // y=0 marks an off-screen invader.
    assign elig[i] = req[i] && (ey[i] != 10'd0);
  end

  function automatic logic [9:0] clamp_x(
    input logic [9:0] v
  );
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  // First eligible index after last, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NREQ-1:0] m,
    input logic [IW-1:0]   last
  );
    logic [IW-1:0] p;
    logic          f;
    int            j;
    p = last;
    f = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!f && m[j]) begin
        p = IW'(j);
        f = 1'b1;
      end
    end
    return p;
  endfunction

`ifdef ENEMY_FIRE_HOMING_EN
  // One pixel toward target; both ends clamped so
  // the step never leaves 0..639.
  function automatic logic [9:0] home_step(
    input logic [9:0] px,
    input logic [9:0] tx
  );
    logic [9:0] p;
    logic [9:0] t;
    p = clamp_x(px);
    t = clamp_x(tx);
    if (p < t) begin
      return p + 10'd1;
    end else if (p > t) begin
      return p - 10'd1;
    end
    return p;
  endfunction
`else
  logic unused_player_x;
  assign unused_player_x = ^player_x;
`endif

  assign pick = rr_pick(elig, last_q);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      winner_q    <= '0;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      grant       <= '0;
      proj_x      <= '0;
      proj_y      <= '0;
      proj_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant       <= grant_d;
      proj_x      <= px_d;
      proj_y      <= py_d;
      proj_active <= act_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    px_d     = proj_x;
    py_d     = proj_y;
    act_d    = proj_active;

    if (!play) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      px_d    = '0;
      py_d    = '0;
      act_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|elig) begin
            winner_d = pick;
            state_d  = S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          grant_d = NREQ'(1) << winner_q;
          px_d    = clamp_x(ex[winner_q]);
          py_d    = ey[winner_q];
          act_d   = 1'b1;
          last_d  = winner_q;
          state_d = S_FLIGHT;
        end

        S_FLIGHT: begin
          // hit wins over a same-cycle tick.
          if (hit || (tick && proj_y >= Y_LIM)) begin
            state_d = S_COOL;
            cnt_d   = CD_LOAD;
            px_d    = '0;
            py_d    = '0;
            act_d   = 1'b0;
          end else if (tick) begin
            py_d = (proj_y == Y_TOP) ? proj_y
                                     : proj_y + 10'd1;
`ifdef ENEMY_FIRE_HOMING_EN
            px_d = home_step(proj_x, player_x);
`endif
          end
        end

        S_COOL: begin
          if (cnt_q == 7'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_fire_arbiter.sv
// tb_enemy_fire_arbiter: directed table plus hand sequences for
// enemy_fire_arbiter (default parameters).

module tb_enemy_fire_arbiter;

  logic        dclk;
  logic        clr;
  logic        play;
  logic        tick;
  logic [3:0]  req;
  logic [39:0] enemy_x;
  logic [39:0] enemy_y;
  logic [9:0]  player_x;
  logic        hit;
  logic [3:0]  grant;
  logic [9:0]  proj_x;
  logic [9:0]  proj_y;
  logic        proj_active;

  logic [9:0] ex_t [4];
  logic [9:0] ey_t [4];

  assign enemy_x = {ex_t[3], ex_t[2], ex_t[1], ex_t[0]};
  assign enemy_y = {ey_t[3], ey_t[2], ey_t[1], ey_t[0]};

`ifdef ENEMY_FIRE_HOMING_EN
  localparam bit HOME = 1'b1;
`else
  localparam bit HOME = 1'b0;
`endif

  enemy_fire_arbiter dut (
    .dclk        (dclk),
    .clr         (clr),
    .play        (play),
    .tick        (tick),
    .req         (req),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .player_x    (player_x),
    .hit         (hit),
    .grant       (grant),
    .proj_x      (proj_x),
    .proj_y      (proj_y),
    .proj_active (proj_active)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       play;
    logic       tick;
    logic       hit;
    logic [3:0] req;
    logic [3:0] g;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
  } vec_t;

  vec_t tv [6];

  task automatic cyc();
    @(posedge dclk);
    #1;
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] g,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic       a
  );
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".x"}, 32'(proj_x), 32'(x));
    chk({tag, ".y"}, 32'(proj_y), 32'(y));
    chk({tag, ".act"}, 32'(proj_active), 32'(a));
  endtask

  task automatic wait_grant(
    input  int         maxc,
    output int         n,
    output logic [3:0] g
  );
    n = 0;
    g = '0;
    while (n < maxc) begin
      cyc();
      n++;
      if (grant != 4'd0) begin
        g = grant;
        break;
      end
    end
  endtask

  task automatic set_y(input logic [9:0] v);
    for (int i = 0; i < 4; i++) ey_t[i] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         early;
    logic [3:0] g;
    logic [9:0] xe;
    logic [3:0] rr_exp [4];

    clr = 1'b1;
    play = 1'b0;
    tick = 1'b0;
    hit = 1'b0;
    req = '0;
    player_x = 10'd100;
    ex_t[0] = 10'd100;
    ex_t[1] = 10'd200;
    ex_t[2] = 10'd300;
    ex_t[3] = 10'd400;
    set_y(10'd30);

    tv[0] = '{1'b1, 1'b0, 1'b0, 4'b0101,
              4'b0000, 10'd0, 10'd0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 4'b0000,
              4'b0001, 10'd100, 10'd30, 1'b1};
    tv[2] = '{1'b1, 1'b1, 1'b0, 4'b0000,
              4'b0000, 10'd100, 10'd31, 1'b1};
    tv[3] = '{1'b1, 1'b0, 1'b0, 4'b1111,
              4'b0000, 10'd100, 10'd31, 1'b1};
    tv[4] = '{1'b1, 1'b1, 1'b0, 4'b1111,
              4'b0000, 10'd100, 10'd32, 1'b1};
    tv[5] = '{1'b1, 1'b1, 1'b1, 4'b0101,
              4'b0000, 10'd0, 10'd0, 1'b0};

    // reset state
    cyc();
    cyc();
    chk_out("reset", 4'd0, 10'd0, 10'd0, 1'b0);
    clr = 1'b0;

    // table: first launch, ticks, ignored req, hit
    for (int i = 0; i < 6; i++) begin
      play = tv[i].play;
      tick = tv[i].tick;
      hit  = tv[i].hit;
      req  = tv[i].req;
      cyc();
      chk_out($sformatf("tv%0d", i),
              tv[i].g, tv[i].x, tv[i].y, tv[i].act);
    end
    tick = 1'b0;
    hit  = 1'b0;

    // cooldown: 64 cycles, then IDLE, LAUNCH, grant
    early = 0;
    for (int i = 1; i <= 65; i++) begin
      cyc();
      if (grant != 4'd0) early++;
    end
    chk("cool_quiet", 32'(early), 32'd0);
    cyc();
    chk_out("rr_second", 4'b0100, 10'd300,
            10'd30, 1'b1);

    // play drop in flight
    play = 1'b0;
    req = '0;
    cyc();
    chk_out("play_drop", 4'd0, 10'd0, 10'd0, 1'b0);

    // launch from y=470, tick every cycle
    play = 1'b1;
    set_y(10'd470);
    player_x = 10'd103;
    req = 4'b0001;
    cyc();
    chk("launch_gap", 32'(grant), 32'd0);
    req = '0;
    cyc();
    chk_out("y470", 4'b0001, 10'd100, 10'd470, 1'b1);
    tick = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      if (i <= 10) begin
        xe = 10'd100;
        if (HOME) xe = (i >= 3) ? 10'd103 : 10'(100 + i);
        chk($sformatf("fly%0d.y", i),
            32'(proj_y), 32'(470 + i));
        chk($sformatf("fly%0d.x", i),
            32'(proj_x), 32'(xe));
        chk($sformatf("fly%0d.act", i),
            32'(proj_active), 32'd1);
      end else begin
        chk("retire.y", 32'(proj_y), 32'd0);
        chk("retire.act", 32'(proj_active), 32'd0);
      end
    end
    tick = 1'b0;
    set_y(10'd200);
    req = 4'b0001;
    wait_grant(100, n, g);
    chk("retire_lat", 32'(n), 32'd66);
    chk("retire_g", 32'(g), 32'b0001);
    chk("retire_y", 32'(proj_y), 32'd200);

    // hit and tick together at y=200
    req = '0;
    hit = 1'b1;
    tick = 1'b1;
    cyc();
    hit = 1'b0;
    tick = 1'b0;
    chk_out("hit_tick", 4'd0, 10'd0, 10'd0, 1'b0);
    req = 4'b0001;
    wait_grant(100, n, g);
    chk("hit_cool_lat", 32'(n), 32'd66);
    chk("hit_cool_g", 32'(g), 32'b0001);

    // clr mid-flight, grant pulse visible now
    clr = 1'b1;
    #1;
    chk_out("clr_flight", 4'd0, 10'd0, 10'd0, 1'b0);
    cyc();
    cyc();
    clr = 1'b0;

    // masked index 2 never granted
    set_y(10'd30);
    ey_t[2] = 10'd0;
    req = 4'b1111;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      wait_grant(100, n, g);
      chk($sformatf("mask_rr%0d", k),
          32'(g), 32'(rr_exp[k]));
      hit = 1'b1;
      cyc();
      hit = 1'b0;
    end

    // clr mid-cooldown, then first grant to index 0
    req = '0;
    for (int i = 0; i < 5; i++) cyc();
    #2;
    clr = 1'b1;
    #1;
    chk_out("clr_cool", 4'd0, 10'd0, 10'd0, 1'b0);
    cyc();
    clr = 1'b0;
    set_y(10'd30);
    req = 4'b1111;
    wait_grant(100, n, g);
    chk("post_rst_g", 32'(g), 32'b0001);
    chk("post_rst_lat", 32'(n), 32'd2);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
